// File: rtl/ntm_convolutional_fnn_matrix_streamer_pkg.sv
// Shared definitions for the FNN weight streamer: data/control widths and the
// streamer state encoding.
package ntm_convolutional_fnn_matrix_streamer_pkg;

    localparam int DATA_SIZE    = 64;
    localparam int CONTROL_SIZE = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_OUTPUT,
        ST_DONE
    } streamer_state_t;

endpackage

// File: rtl/ntm_convolutional_fnn_matrix_streamer_index_counter.sv
// Row/column/address walker for a row-major L x X matrix. The address is a
// running counter, so no multiplier is needed and it wraps naturally.
module ntm_matrix_index_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         advance,
    input  logic [W-1:0] size_l,
    input  logic [W-1:0] size_x,
    input  logic [W-1:0] base,
    output logic [W-1:0] addr,
    output logic         first_col,
    output logic         last
);

    logic [W-1:0] size_l_q;
    logic [W-1:0] size_x_q;
    logic [W-1:0] l_idx;
    logic [W-1:0] x_idx;
    logic         row_end;

    assign row_end   = (x_idx == size_x_q - W'(1));
    assign last      = row_end && (l_idx == size_l_q - W'(1));
    assign first_col = (x_idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            size_l_q <= '0;
            size_x_q <= '0;
            l_idx    <= '0;
            x_idx    <= '0;
            addr     <= '0;
        end else if (load) begin
            size_l_q <= size_l;
            size_x_q <= size_x;
            l_idx    <= '0;
            x_idx    <= '0;
            addr     <= base;
        end else if (advance) begin
            addr <= addr + W'(1);
            if (row_end) begin
                x_idx <= '0;
                l_idx <= l_idx + W'(1);
            end else begin
                x_idx <= x_idx + W'(1);
            end
        end
    end

endmodule

// File: rtl/ntm_convolutional_fnn_matrix_streamer.sv
// Element-serial weight source: fetches an L x X matrix from a 1-cycle SRAM and
// presents one element at a time to the FNN W_IN port with an ACK handshake.
module ntm_convolutional_fnn_matrix_streamer #(
    parameter int DATA_SIZE    = ntm_convolutional_fnn_matrix_streamer_pkg::DATA_SIZE,
    parameter int CONTROL_SIZE = ntm_convolutional_fnn_matrix_streamer_pkg::CONTROL_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    ready,
    input  logic [CONTROL_SIZE-1:0] size_l_in,
    input  logic [CONTROL_SIZE-1:0] size_x_in,
    input  logic [CONTROL_SIZE-1:0] base_addr_in,
    output logic                    mem_rd_en,
    output logic [CONTROL_SIZE-1:0] mem_addr,
    input  logic [DATA_SIZE-1:0]    mem_rd_data,
    output logic [DATA_SIZE-1:0]    w_out,
    output logic                    w_out_x_enable,
    output logic                    w_out_l_enable,
    input  logic                    w_out_ack
);

    import ntm_convolutional_fnn_matrix_streamer_pkg::*;

    streamer_state_t         state;
    streamer_state_t         state_nxt;
    logic                    load;
    logic                    advance;
    logic                    sizes_ok;
    logic                    first_col;
    logic                    last;
    logic [CONTROL_SIZE-1:0] addr;

    ntm_matrix_index_counter #(
        .W (CONTROL_SIZE)
    ) u_index (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .size_l    (size_l_in),
        .size_x    (size_x_in),
        .base      (base_addr_in),
        .addr      (addr),
        .first_col (first_col),
        .last      (last)
    );

    assign sizes_ok = (size_l_in != '0) && (size_x_in != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read data is only valid the cycle after the strobe, i.e. during WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_out <= '0;
        end else if (state == ST_WAIT) begin
            w_out <= mem_rd_data;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (sizes_ok) begin
                        load      = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_FETCH:  state_nxt = ST_WAIT;
            ST_WAIT:   state_nxt = ST_OUTPUT;
            ST_OUTPUT: begin
                if (w_out_ack) begin
                    advance   = 1'b1;
                    state_nxt = last ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign mem_rd_en      = (state == ST_FETCH);
    assign mem_addr       = mem_rd_en ? addr : '0;
    assign w_out_x_enable = (state == ST_OUTPUT);
    assign w_out_l_enable = (state == ST_OUTPUT) && first_col;
    assign ready          = (state == ST_DONE);

endmodule

// File: tb/tb_ntm_convolutional_fnn_matrix_streamer.sv
// Self-checking bench for the FNN weight streamer: table of directed transfers,
// randomized transfers against an event-timing reference model, plus corner sequences.
module tb_ntm_convolutional_fnn_matrix_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [63:0] size_l_in;
    logic [63:0] size_x_in;
    logic [63:0] base_addr_in;
    logic        mem_rd_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_rd_data;
    logic [63:0] w_out;
    logic        w_out_x_enable;
    logic        w_out_l_enable;
    logic        w_out_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ntm_convolutional_fnn_matrix_streamer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ready          (ready),
        .size_l_in      (size_l_in),
        .size_x_in      (size_x_in),
        .base_addr_in   (base_addr_in),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .w_out          (w_out),
        .w_out_x_enable (w_out_x_enable),
        .w_out_l_enable (w_out_l_enable),
        .w_out_ack      (w_out_ack)
    );

    function automatic logic [63:0] mem_f(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'hDEAD_BEEF_0000_1111;
    endfunction

    // 1-cycle latency SRAM; junk on the bus whenever no read was issued
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_f(mem_addr);
        else           mem_rd_data <= {$urandom, $urandom};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ready"}, 64'(ready), 64'd0);
        chk({name, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({name, "_addr"}, mem_addr, 64'd0);
        chk({name, "_w_out"}, w_out, 64'd0);
        chk({name, "_x_en"}, 64'(w_out_x_enable), 64'd0);
        chk({name, "_l_en"}, 64'(w_out_l_enable), 64'd0);
    endtask

    typedef struct {
        int          l;
        int          x;
        logic [63:0] base;
        int          stall_elem;
        int          stall_len;
        int          ack_mode;   // 0: ack high except stall, 1: random ack
        int          perturb;    // random start pulses / size+base changes mid-transfer
        int          rst_cycle;  // -1: no reset
        int          exp_ready;  // -1: not checked against a constant
    } vec_t;

    task automatic run_vec(input vec_t v);
        int   n_total, n_rd, n_acc, next_rd, out_start, ready_cyc, seen_ready, stall_left;
        logic pending, exp_rd, exp_xen, exp_rdy, exp_len, accept, finished;
        n_total    = v.l * v.x;
        n_rd       = 0;
        n_acc      = 0;
        pending    = 1'b0;
        out_start  = -1;
        seen_ready = -1;
        stall_left = v.stall_len;
        finished   = 1'b0;
        next_rd    = (n_total == 0) ? -1 : 1;
        ready_cyc  = (n_total == 0) ? 1 : -1;

        @(negedge clk);
        start        = 1'b1;
        size_l_in    = 64'(v.l);
        size_x_in    = 64'(v.x);
        base_addr_in = v.base;
        w_out_ack    = 1'b0;

        for (int c = 1; c <= 400 && !finished; c++) begin
            @(negedge clk);
            if (v.rst_cycle >= 0 && c > v.rst_cycle) begin
                chk_all_zero("after_rst");
                rst   = 1'b0;
                start = 1'b0;
                if (c == v.rst_cycle + 4) finished = 1'b1;
                continue;
            end
            exp_rd  = (c == next_rd);
            exp_xen = pending && (c >= out_start);
            exp_rdy = (c == ready_cyc);
            exp_len = 1'b0;
            if (exp_xen && v.x != 0) exp_len = ((n_acc % v.x) == 0);

            chk("rd_en", 64'(mem_rd_en), 64'(exp_rd));
            chk("x_en", 64'(w_out_x_enable), 64'(exp_xen));
            chk("l_en", 64'(w_out_l_enable), 64'(exp_len));
            chk("ready", 64'(ready), 64'(exp_rdy));
            chk("exclusive", 64'(int'(ready) + int'(mem_rd_en) + int'(w_out_x_enable) <= 1), 64'd1);
            if (exp_rd)  chk("mem_addr", mem_addr, v.base + 64'(n_rd));
            if (exp_xen) chk("w_out", w_out, mem_f(v.base + 64'(n_acc)));
            if (ready === 1'b1) seen_ready = c;

            if (ready_cyc >= 0 && c == ready_cyc + 1) begin
                start     = 1'b0;
                w_out_ack = 1'b0;
                finished  = 1'b1;
                continue;
            end

            if (exp_rd) begin
                pending   = 1'b1;
                out_start = c + 2;
                n_rd++;
            end

            if (v.ack_mode == 1)
                w_out_ack = 1'($urandom_range(0, 1));
            else if (exp_xen && n_acc == v.stall_elem && stall_left > 0) begin
                w_out_ack = 1'b0;
                stall_left--;
            end else
                w_out_ack = 1'b1;

            if (v.perturb != 0) begin
                start        = 1'($urandom_range(0, 1));
                size_l_in    = 64'($urandom_range(0, 6));
                size_x_in    = 64'($urandom_range(0, 6));
                base_addr_in = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end

            if (c == v.rst_cycle) begin
                rst = 1'b1;
                continue;
            end

            accept = exp_xen && w_out_ack;
            if (accept) begin
                pending = 1'b0;
                n_acc++;
                if (n_acc == n_total) ready_cyc = c + 1;
                else                  next_rd   = c + 1;
            end
        end
        if (!finished) chk("timeout", 64'd1, 64'd0);
        if (v.rst_cycle >= 0) chk("no_ready_after_rst", 64'(seen_ready >= 0), 64'd0);
        if (v.exp_ready >= 0) chk("ready_cycle", 64'(seen_ready), 64'(v.exp_ready));
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        size_l_in    = '0;
        size_x_in    = '0;
        base_addr_in = '0;
        w_out_ack    = 1'b0;

        vecs[0] = '{2, 3, 64'h10, -1, 0, 0, 0, -1, 19};
        vecs[1] = '{2, 3, 64'h10,  2, 4, 0, 0, -1, 23};
        vecs[2] = '{0, 5, 64'h10, -1, 0, 0, 0, -1, 1};
        vecs[3] = '{4, 0, 64'h10, -1, 0, 0, 0, -1, 1};
        vecs[4] = '{2, 3, 64'h10, -1, 0, 0, 0,  8, -1};
        vecs[5] = '{2, 3, 64'h10, -1, 0, 0, 0, -1, 19};
        vecs[6] = '{2, 3, 64'h10, -1, 0, 0, 1, -1, 19};
        vecs[7] = '{1, 4, 64'hFFFF_FFFF_FFFF_FFFE, -1, 0, 0, 0, -1, 13};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // START during the READY cycle is ignored; accepted the cycle after
        @(negedge clk);
        start = 1'b1; size_l_in = 64'd0; size_x_in = 64'd5;
        @(negedge clk);
        chk("seq_ready1", 64'(ready), 64'd1);
        @(negedge clk);
        chk("seq_ignored_start", 64'(ready), 64'd0);
        chk("seq_no_rd", 64'(mem_rd_en), 64'd0);
        @(negedge clk);
        chk("seq_ready2", 64'(ready), 64'd1);
        start = 1'b0;
        @(negedge clk);
        chk("seq_idle", 64'(ready), 64'd0);

        for (int k = 0; k < 12; k++) begin
            rv.l          = $urandom_range(1, 4);
            rv.x          = $urandom_range(1, 4);
            rv.base       = (k % 3 == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)))
                                         : {$urandom, $urandom};
            rv.stall_elem = -1;
            rv.stall_len  = 0;
            rv.ack_mode   = (k % 2);
            rv.perturb    = (k % 4 == 1) ? 1 : 0;
            rv.rst_cycle  = -1;
            rv.exp_ready  = (rv.ack_mode == 0) ? 3 * rv.l * rv.x + 1 : -1;
            run_vec(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
